// File: rtl/dot_accum.sv
// Saturating signed dot-product accumulator fed by a sequential multiplier's rdy/p outputs.
// Sums N_TERMS products, then holds the result on a valid/ready handshake.
module dot_accum #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [15:0]      p,
    input  logic             rdy,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [7:0]       term_cnt,
    output logic             ovf,
    output logic             drop
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [ACC_W-1:0] SUM_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SUM_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [7:0]       CNT_LAST = 8'(N_TERMS);

    state_t           state_reg, state_next;
    logic             rdy_q_reg;
    logic [ACC_W-1:0] sum_reg, sum_next;
    logic [7:0]       term_cnt_reg, term_cnt_next;
    logic             ovf_reg, ovf_next;
    logic             drop_reg, drop_next;
    logic             sum_valid_reg;

    logic             acc_en;
    logic [ACC_W:0]   p_ext;
    logic [ACC_W:0]   add_full;
    logic             sat_hi, sat_lo;
    logic [ACC_W-1:0] sum_sat;
    logic [7:0]       cnt_inc;

    assign acc_en = rdy & ~rdy_q_reg;

    // Sign-extend the product to one guard bit above the accumulator width.
    assign p_ext[15:0] = p;
    genvar gi;
    generate
        for (gi = 16; gi <= ACC_W; gi++) begin : g_pext
            assign p_ext[gi] = p[15];
        end
    endgenerate

    // Guard bit disagreeing with the sign bit means the add left the representable range.
    assign add_full = p_ext + {sum_reg[ACC_W-1], sum_reg};
    assign sat_hi   = ~add_full[ACC_W] &  add_full[ACC_W-1];
    assign sat_lo   =  add_full[ACC_W] & ~add_full[ACC_W-1];
    assign sum_sat  = sat_hi ? SUM_MAX : (sat_lo ? SUM_MIN : add_full[ACC_W-1:0]);
    assign cnt_inc  = term_cnt_reg + 8'd1;

    always_comb begin
        state_next    = state_reg;
        sum_next      = sum_reg;
        term_cnt_next = term_cnt_reg;
        ovf_next      = ovf_reg;
        drop_next     = drop_reg;
        if (clr) begin
            state_next    = ACCUM;
            sum_next      = '0;
            term_cnt_next = '0;
            ovf_next      = 1'b0;
            drop_next     = 1'b0;
        end else if (state_reg == HOLD) begin
            if (acc_en) begin
                drop_next = 1'b1;
            end
            if (sum_ready) begin
                state_next    = ACCUM;
                sum_next      = '0;
                term_cnt_next = '0;
                ovf_next      = 1'b0;
            end
        end else if (acc_en) begin
            sum_next      = sum_sat;
            term_cnt_next = cnt_inc;
            ovf_next      = ovf_reg | sat_hi | sat_lo;
            if (cnt_inc == CNT_LAST) begin
                state_next = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ACCUM;
            rdy_q_reg     <= 1'b1;
            sum_reg       <= '0;
            term_cnt_reg  <= '0;
            ovf_reg       <= 1'b0;
            drop_reg      <= 1'b0;
            sum_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rdy_q_reg     <= rdy;
            sum_reg       <= sum_next;
            term_cnt_reg  <= term_cnt_next;
            ovf_reg       <= ovf_next;
            drop_reg      <= drop_next;
            sum_valid_reg <= (state_next == HOLD);
        end
    end

    assign sum       = sum_reg;
    assign sum_valid = sum_valid_reg;
    assign term_cnt  = term_cnt_reg;
    assign ovf       = ovf_reg;
    assign drop      = drop_reg;
endmodule

// File: tb/tb_dot_accum.sv
// Scoreboard bench for dot_accum: a 24-bit and a 16-bit instance share one stimulus stream.
module tb_dot_accum;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] p = '0;
    logic        rdy = 1'b0;
    logic        sum_ready = 1'b0;

    logic [23:0] sum;
    logic        sum_valid, ovf, drop;
    logic [7:0]  term_cnt;
    logic [15:0] sum16;
    logic        sum_valid16, ovf16, drop16;
    logic [7:0]  term_cnt16;

    always #5 clk = ~clk;

    dot_accum #(.N_TERMS(4), .ACC_W(24)) dut (
        .clk(clk), .reset(reset), .clr(clr), .p(p), .rdy(rdy),
        .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .term_cnt(term_cnt), .ovf(ovf), .drop(drop)
    );

    dot_accum #(.N_TERMS(4), .ACC_W(16)) dut16 (
        .clk(clk), .reset(reset), .clr(clr), .p(p), .rdy(rdy),
        .sum(sum16), .sum_valid(sum_valid16), .sum_ready(sum_ready),
        .term_cnt(term_cnt16), .ovf(ovf16), .drop(drop16)
    );

    typedef struct packed {
        logic [23:0] s24;
        logic [15:0] s16;
        logic        o24;
        logic        o16;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;

    // Reference model state
    longint m24, m16;
    logic   mo24, mo16, mhold, mdrop;
    int     mcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic model_clear(input logic clear_drop);
        m24 = 0; m16 = 0; mo24 = 1'b0; mo16 = 1'b0; mcnt = 0; mhold = 1'b0;
        if (clear_drop) mdrop = 1'b0;
    endtask

    task automatic model_add(input logic [15:0] pv);
        longint r, hi;
        r  = m24 + longint'($signed(pv));
        hi = (longint'(1) <<< 23) - 1;
        if (r > hi) begin r = hi; mo24 = 1'b1; end
        if (r < -hi - 1) begin r = -hi - 1; mo24 = 1'b1; end
        m24 = r;
        r  = m16 + longint'($signed(pv));
        hi = 32767;
        if (r > hi) begin r = hi; mo16 = 1'b1; end
        if (r < -hi - 1) begin r = -hi - 1; mo16 = 1'b1; end
        m16 = r;
        mcnt++;
        if (mcnt == 4) begin
            sb.push_back('{s24: m24[23:0], s16: m16[15:0], o24: mo24, o16: mo16});
            mhold = 1'b1;
        end
    endtask

    // One rising rdy edge: high for one sampled edge, then low for one.
    task automatic pulse(input logic [15:0] pv);
        @(negedge clk);
        p = pv; rdy = 1'b1;
        if (mhold) mdrop = 1'b1;
        else model_add(pv);
        @(negedge clk);
        rdy = 1'b0;
    endtask

    // Wait (bounded) for a held result, compare it against the scoreboard, then accept it.
    task automatic take(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!sum_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(sum_valid), 32'd1);
        check({tag, "_valid16"}, 32'(sum_valid16), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_sum"}, 32'(sum), 32'(e.s24));
        check({tag, "_sum16"}, 32'(sum16), 32'(e.s16));
        check({tag, "_ovf"}, 32'(ovf), 32'(e.o24));
        check({tag, "_ovf16"}, 32'(ovf16), 32'(e.o16));
        check({tag, "_cnt"}, 32'(term_cnt), 32'd4);
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        model_clear(1'b0);
        check({tag, "_post_valid"}, 32'(sum_valid), 32'd0);
        check({tag, "_post_sum"}, 32'(sum), 32'd0);
        check({tag, "_post_cnt"}, 32'(term_cnt), 32'd0);
        check({tag, "_post_drop"}, 32'(drop), 32'(mdrop));
    endtask

    initial begin
        model_clear(1'b1);
        rdy = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_valid", 32'(sum_valid), 32'd0);
        check("rst_cnt", 32'(term_cnt), 32'd0);
        check("rst_ovf_drop", {30'd0, ovf, drop}, 32'd0);
        // rdy already high at reset release must not count
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rdy_high_at_release", 32'(term_cnt), 32'd0);
        rdy = 1'b0;
        @(negedge clk);

        // Basic sum with default widths
        pulse(16'h000F); pulse(16'hFFFA); pulse(16'h0064); pulse(16'h8000);
        check("basic_const", 32'(sum), 32'hFF806D);
        take("basic");

        // Saturation in the 16-bit instance
        pulse(16'h7FFF); pulse(16'h0001);
        check("sat_mid16", 32'(sum16), 32'h7FFF);
        check("sat_mid_ovf16", 32'(ovf16), 32'd1);
        pulse(16'hFFFF); pulse(16'h0000);
        check("sat_const16", 32'(sum16), 32'h7FFE);
        take("sat");

        // Backpressure with a product arriving during HOLD
        pulse(16'h0001); pulse(16'h0002); pulse(16'h0003); pulse(16'h0004);
        repeat (10) @(negedge clk);
        pulse(16'h0005);
        check("bp_sum_frozen", 32'(sum), 32'd10);
        check("bp_drop", 32'(drop), 32'd1);
        take("bp");

        // Level rdy counts once
        @(negedge clk);
        p = 16'h0007; rdy = 1'b1;
        model_add(16'h0007);
        repeat (5) @(negedge clk);
        rdy = 1'b0;
        check("level_cnt", 32'(term_cnt), 32'd1);
        check("level_sum", 32'(sum), 32'd7);
        pulse(16'hFFF0); pulse(16'h0020); pulse(16'h0001);
        take("level");

        // clr coinciding with a rdy edge
        pulse(16'h0011); pulse(16'h0022);
        @(negedge clk);
        p = 16'h0100; rdy = 1'b1; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; rdy = 1'b0;
        model_clear(1'b1);
        @(negedge clk);
        check("clr_sum", 32'(sum), 32'd0);
        check("clr_cnt", 32'(term_cnt), 32'd0);
        check("clr_ovf_drop", {30'd0, ovf, drop}, 32'd0);

        // Asynchronous reset mid-operation
        pulse(16'h0003); pulse(16'h0004);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cnt", 32'(term_cnt), 32'd0);
        check("midrst_flags", {29'd0, sum_valid, ovf, drop}, 32'd0);
        model_clear(1'b1);
        @(negedge clk);
        reset = 1'b1;
        pulse(16'h0002); pulse(16'h0002); pulse(16'h0002); pulse(16'h0002);
        check("midrst_const", 32'(sum), 32'h000008);
        take("midrst");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dot_accum.md
# dot_accum

Downstream consumer for the sequential multiplier: watches the multiplier's `rdy`, captures each finished 16-bit signed product `p` on the rising edge of `rdy`, and accumulates `N_TERMS` products into a saturating signed dot-product sum. The completed sum is presented on a valid/ready output handshake. Overflow is flagged sticky. Products arriving while a result is held are dropped and flagged.

## Interface
- `N_TERMS`, 4: products per dot product; legal range 1..255.
- `ACC_W`, 24: accumulator/sum width in bits; legal range 16..32.

- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset); takes effect immediately, released synchronously to `clk` by the system.
- `clr`  in  1  synchronous clear / start new dot product.
- `p`  in  16  product from the multiplier, two's complement.
- `rdy`  in  1  multiplier done level; held high until the multiplier is restarted.
- `sum`  out  ACC_W  accumulated signed sum.
- `sum_valid`  out  1  `sum` is complete and held.
- `sum_ready`  in  1  consumer accepts `sum`.
- `term_cnt`  out  8  products accepted in the current dot product.
- `ovf`  out  1  sticky saturation flag for the current dot product.
- `drop`  out  1  sticky: a product edge arrived while in HOLD.

## Operation
- Edge detect: register `rdy_q`, reset value 1. Accept event `acc_en = rdy & ~rdy_q`. A `rdy` already high at reset release is not accepted until it falls and rises again.
- `p` is sign-extended to ACC_W+1 bits and added to `sum`, which is also sign-extended.
- Saturation: if the result exceeds `2^(ACC_W-1)-1`, `sum` is set to that maximum. If the result is below `-2^(ACC_W-1)`, `sum` is set to that minimum. In both cases `ovf` is set to 1.
- Later adds start from the saturated value; no wrap-around ever occurs.
- States:
  - ACCUM: on `acc_en`, update `sum` and increment `term_cnt`. When the accepted product makes `term_cnt == N_TERMS`, go to HOLD.
  - HOLD: `sum_valid=1`. `sum`, `term_cnt` and `ovf` are frozen. Any `acc_en` sets `drop=1` and is otherwise ignored.
  - On `sum_valid & sum_ready`: go to ACCUM and clear `sum`, `term_cnt` and `ovf`. `drop` is kept.
- `clr` has highest priority in either state. It returns the block to ACCUM and clears `sum`, `term_cnt`, `ovf` and `drop`. An `acc_en` in the same cycle is discarded.
- Same-cycle handshake and `acc_en` in HOLD: the handshake completes, the product is dropped, and `drop` is set to 1.
- Reset values: `sum=0`, `sum_valid=0`, `term_cnt=0`, `ovf=0`, `drop=0`, state ACCUM, `rdy_q=1`.

## Timing
- `p` is sampled on the same rising edge where `rdy=1` and `rdy_q=0`. `sum` shows the new value after that edge (1-cycle latency).
- `sum_valid` rises on the same edge that accepts the N_TERMS-th product.
- `sum_valid` falls on the edge where `sum_ready=1` is sampled. The earliest next acceptance is the following edge.
- Minimum spacing between accepted products is 2 cycles, because `rdy` must be low for at least one sampled edge.
- Asserting `reset` mid-operation forces all outputs to their reset values immediately. The partial sum is lost.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Basic sum, defaults: feed four `rdy` pulses with `p` = 0x000F, 0xFFFA, 0x0064, 0x8000 -> after the 4th edge, `sum_valid=1`, `sum=0xFF806D`, `term_cnt=4`, `ovf=0`.
- Saturation, ACC_W=16: feed `p` = 0x7FFF, 0x0001, 0xFFFF, 0x0000 -> `sum` is 0x7FFF after term 2, then 0x7FFE; final `sum=0x7FFE`, `ovf=1`.
- Backpressure: complete a sum with `sum_ready=0` for 10 cycles and pulse `rdy` with `p=0x0005` during HOLD -> `sum` unchanged and `drop=1`. Then set `sum_ready=1` -> next cycle `sum_valid=0`, `sum=0`, `term_cnt=0`, `drop=1`.
- Level `rdy`: hold `rdy` high for 5 cycles -> exactly one product accepted, `term_cnt=1`.
- `clr` with `rdy` edge: after 2 terms, assert `clr` on the cycle of a `rdy` rising edge -> `sum=0`, `term_cnt=0`, `ovf=0`, `drop=0`, and the product is not added.
- Reset mid-op: after 2 terms, drive `reset=0` for 1 cycle -> all outputs 0 immediately. Then four products of 0x0002 -> `sum=0x000008`.
